fifo_rd_stream: RTL and testbench

Read-side adapter for the asynchronous FIFO IP, instantiated on the `rd_clk` side of `fifo_generator_0`. It pulls words from the FIFO's `rd_en`/`rd_data`/`rd_empty` port and delivers them on a valid/ready stream with no loss or duplication. It absorbs the FIFO's fixed read latency (1 or 2 cycles, per the IP's `OUTPUT_REG` setting) using a small credit-controlled skid buffer. It also keeps a word counter and a sticky overflow flag for verification.

---
 rtl/fifo_rd_pkg.sv | 17 +
 rtl/fifo_rd_stream_if.sv | 14 +
 rtl/fifo_rd_skid.sv | 56 +++++
 rtl/fifo_rd_stream.sv | 70 +++++++
 tb/tb_fifo_rd_stream.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared constants and configuration checks for the FIFO read-side stream adapter.
package fifo_rd_pkg;

    // Read latency of fifo_generator_0 without / with its output register
    localparam int RD_LAT_NO_OREG = 1;
    localparam int RD_LAT_OREG    = 2;

    // Skid depth must be a power of two with room for every word in flight plus one being popped
    function automatic bit buf_depth_ok(input int depth, input int rd_lat);
        bit lat_ok;
        bit pow2;
        lat_ok = (rd_lat == RD_LAT_NO_OREG) || (rd_lat == RD_LAT_OREG);
        pow2   = (depth > 0) && ((depth & (depth - 1)) == 0);
        return lat_ok && pow2 && (depth >= rd_lat + 2);
    endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream carrying words read out of the asynchronous FIFO.
interface fifo_rd_stream_if #(
    parameter int DATA_WIDTH = 8
);
    // A beat transfers on a clock edge where m_valid && m_ready; once m_valid is high,
    // m_valid and m_data hold until that edge, and m_valid never waits on m_ready.
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);

endinterface

// File: rtl/fifo_rd_skid.sv
// Circular skid buffer that holds FIFO words until the stream side accepts them.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 4,
    localparam int PTR_W     = $clog2(BUF_DEPTH),
    localparam int OCC_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  tb_rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  m_ready,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  pop,
    output logic [OCC_W-1:0]      occ,
    output logic                  ovf_err
);

    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  full;
    logic                  push_ok;

    assign full    = (occ == OCC_FULL);
    assign m_valid = (occ != '0);
    assign m_data  = mem[rd_ptr];
    assign pop     = m_valid && m_ready;
    // A full buffer still accepts a word when the head leaves on the same edge
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            ovf_err <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      occ <= occ + 1'b1;
            else if (!push_ok && pop) occ <= occ - 1'b1;
            if (push && full && !pop) ovf_err <= 1'b1;
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter: issues FIFO reads against skid-buffer credit and presents words on a stream.
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int BUF_DEPTH  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  tb_rst,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_empty,
    input  logic                  almost_empty,
    fifo_rd_stream_if.master      m,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic                  ovf_err,
    output logic                  busy
);

    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int CMT_W = OCC_W + 1;

    if (!buf_depth_ok(BUF_DEPTH, RD_LATENCY)) begin : g_bad_cfg
        $error("fifo_rd_stream: illegal BUF_DEPTH / RD_LATENCY combination");
    end

    logic [RD_LATENCY-1:0] inflight;
    logic [OCC_W-1:0]      occ;
    logic [CMT_W-1:0]      committed;
    logic                  rd_valid;
    logic                  pop;
    logic                  unused_almost_empty;

    assign unused_almost_empty = almost_empty;

    // Credit counts words buffered plus reads already issued; m_ready is deliberately absent
    assign committed = CMT_W'(occ) + CMT_W'($countones(inflight));
    assign rd_en     = !rd_empty && (committed < CMT_W'(BUF_DEPTH));
    assign rd_valid  = inflight[RD_LATENCY-1];
    assign busy      = (occ != '0) || (|inflight) || !rd_empty;

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            inflight <= '0;
            word_cnt <= '0;
        end else begin
            inflight <= RD_LATENCY'({inflight, rd_en});
            if (pop) word_cnt <= word_cnt + 1'b1;
        end
    end

    fifo_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_skid (
        .clk       (clk),
        .tb_rst    (tb_rst),
        .push      (rd_valid),
        .push_data (rd_data),
        .m_ready   (m.m_ready),
        .m_valid   (m.m_valid),
        .m_data    (m.m_data),
        .pop       (pop),
        .occ       (occ),
        .ovf_err   (ovf_err)
    );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based FIFO model with fixed read latency, scoreboard on the stream side.
`timescale 1ns/1ps
module tb_fifo_rd_stream;
  import fifo_rd_pkg::*;

  localparam int DW     = 8;
  localparam int RD_LAT = RD_LAT_OREG;
  localparam int DEPTH  = 4;
  localparam int CW     = 16;

  logic          clk;
  logic          tb_rst;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_empty;
  logic          almost_empty;
  logic [CW-1:0] word_cnt;
  logic          ovf_err;
  logic          busy;

  fifo_rd_stream_if #(.DATA_WIDTH(DW)) s_if ();

  fifo_rd_stream #(
    .DATA_WIDTH (DW),
    .RD_LATENCY (RD_LAT),
    .BUF_DEPTH  (DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk          (clk),
    .tb_rst       (tb_rst),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_empty     (rd_empty),
    .almost_empty (almost_empty),
    .m            (s_if),
    .word_cnt     (word_cnt),
    .ovf_err      (ovf_err),
    .busy         (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] pipe[RD_LAT];
  int            rd_en_pulses = 0;
  int            exp_wc = 0;
  bit            en_next;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO IP model: a read sampled at edge N shows its word on rd_data RD_LAT-1 edges later
  initial begin
    for (int i = 0; i < RD_LAT; i++) pipe[i] = '0;
    rd_data = '0;
    rd_empty = 1'b1;
    almost_empty = 1'b1;
    forever begin
      @(negedge clk);
      en_next = rd_en;
      if (rd_empty) check("rd_en_while_empty", 32'(rd_en), 32'd0);
      if (en_next) rd_en_pulses++;
      @(posedge clk);
      #1;
      for (int i = RD_LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
      if (en_next && !tb_rst && fifo_q.size() > 0) pipe[0] = fifo_q.pop_front();
      else pipe[0] = DW'($urandom);
      rd_data = pipe[RD_LAT-1];
      rd_empty = (fifo_q.size() == 0);
      almost_empty = (fifo_q.size() < 2);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_seq(input int n, input bit rnd);
    logic [DW-1:0] w;
    @(posedge clk);
    #2;
    for (int i = 0; i < n; i++) begin
      w = rnd ? DW'($urandom) : DW'(255 - i);
      fifo_q.push_back(w);
      exp_q.push_back(w);
    end
    exp_wc += n;
    rd_empty = (fifo_q.size() == 0);
    almost_empty = (fifo_q.size() < 2);
  endtask

  task automatic wait_drain(input int budget, input bit rnd_ready, input string name);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || s_if.m_valid) && c < budget) begin
      @(posedge clk);
      #1;
      if (rnd_ready) s_if.m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      #1;
      c++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic apply_reset(input int cycles);
    tb_rst = 1'b1;
    fifo_q.delete();
    exp_q.delete();
    exp_wc = 0;
    rd_empty = 1'b1;
    almost_empty = 1'b1;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    tb_rst = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!tb_rst && s_if.m_valid) begin
        if (exp_q.size() == 0) check("unexpected_beat", 32'(s_if.m_data), 32'hFFFF_FFFF);
        else begin
          check("m_data", 32'(s_if.m_data), 32'(exp_q[0]));
          if (s_if.m_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int gaps;
    int n;
    s_if.m_ready = 1'b0;
    tb_rst = 1'b0;
    #2;
    tb_rst = 1'b1;
    #190;
    check("rst_m_valid", 32'(s_if.m_valid), 32'd0);
    check("rst_m_data", 32'(s_if.m_data), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    check("rst_ovf_err", 32'(ovf_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    @(negedge clk);
    tb_rst = 1'b0;
    repeat (3) @(posedge clk);

    // sustained drain with first-word latency
    s_if.m_ready = 1'b1;
    write_seq(256, 1'b0);
    cyc = 0;
    do begin
      @(posedge clk);
      #3;
      cyc++;
    end while (!s_if.m_valid && cyc < 20);
    check("first_word_latency", 32'(cyc), 32'(RD_LAT + 1));
    gaps = 0;
    for (int i = 1; i < 256; i++) begin
      @(posedge clk);
      #3;
      if (!s_if.m_valid) gaps++;
    end
    check("drain_gaps", 32'(gaps), 32'd0);
    wait_drain(50, 1'b0, "drain_complete");
    check("word_cnt_drain", 32'(word_cnt), 32'(exp_wc % 65536));
    check("ovf_drain", 32'(ovf_err), 32'd0);

    // backpressure
    s_if.m_ready = 1'b0;
    rd_en_pulses = 0;
    write_seq(256, 1'b0);
    repeat (20) @(posedge clk);
    #3;
    check("bp_rd_en_pulses", 32'(rd_en_pulses), 32'(DEPTH));
    check("bp_m_valid", 32'(s_if.m_valid), 32'd1);
    s_if.m_ready = 1'b1;
    wait_drain(400, 1'b0, "bp_drain_complete");
    check("word_cnt_bp", 32'(word_cnt), 32'(exp_wc % 65536));

    // random data, random ready, writes landing mid-stream
    for (int k = 0; k < 5; k++) begin
      n = $urandom_range(5, 40);
      write_seq(n, 1'b1);
      repeat ($urandom_range(3, 30)) begin
        @(posedge clk);
        #1;
        s_if.m_ready = 1'($urandom_range(0, 1));
      end
    end
    wait_drain(2000, 1'b1, "rand_drain_complete");
    check("word_cnt_rand", 32'(word_cnt), 32'(exp_wc % 65536));
    check("ovf_rand", 32'(ovf_err), 32'd0);

    // empty mid-stream
    s_if.m_ready = 1'b1;
    write_seq(5, 1'b1);
    wait_drain(50, 1'b0, "gap_first_drain");
    repeat (4) @(posedge clk);
    #3;
    check("busy_idle_1", 32'(busy), 32'd0);
    write_seq(3, 1'b1);
    wait_drain(50, 1'b0, "gap_second_drain");
    repeat (4) @(posedge clk);
    #3;
    check("busy_idle_2", 32'(busy), 32'd0);
    check("word_cnt_gap", 32'(word_cnt), 32'(exp_wc % 65536));

    // reset with two words buffered and one in flight
    s_if.m_ready = 1'b0;
    write_seq(3, 1'b1);
    repeat (RD_LAT + 2) @(posedge clk);
    #3;
    check("pre_rst_m_valid", 32'(s_if.m_valid), 32'd1);
    check("pre_rst_busy", 32'(busy), 32'd1);
    tb_rst = 1'b1;
    #1;
    check("mid_rst_m_valid", 32'(s_if.m_valid), 32'd0);
    check("mid_rst_word_cnt", 32'(word_cnt), 32'd0);
    apply_reset(3);
    s_if.m_ready = 1'b1;
    repeat (10) @(posedge clk);
    #3;
    check("post_rst_m_valid", 32'(s_if.m_valid), 32'd0);
    check("post_rst_word_cnt", 32'(word_cnt), 32'd0);
    write_seq(4, 1'b1);
    wait_drain(50, 1'b0, "post_rst_drain");
    check("word_cnt_post_rst", 32'(word_cnt), 32'(exp_wc % 65536));
    check("ovf_final", 32'(ovf_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
